// File: rtl/sd_cmd_responder.sv
// SD card command-line responder: receives 48-bit host commands and answers with R1/R2/R6.
// Optional macro SD_RESP_CRC_CHECK_EN discards frames whose received CRC7 is wrong.
module sd_cmd_responder #(
    parameter logic [15:0]  RCA = 16'h0013,
    parameter logic [119:0] CID = 120'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_in,
    output logic        cmd_out,
    output logic        cmd_oe,
    output logic [3:0]  card_state,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    output logic        ill_cmd
);

    typedef enum logic [2:0] {RX_WAIT, RX_SHIFT, DECODE, NCR, TX_SHIFT} st_e;

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_IDENT = 4'd2;
    localparam logic [3:0] S_STBY  = 4'd3;
    localparam logic [3:0] S_TRAN  = 4'd4;

    localparam logic [1:0] RSP_NONE = 2'd0;
    localparam logic [1:0] RSP_R1   = 2'd1;
    localparam logic [1:0] RSP_R6   = 2'd2;
    localparam logic [1:0] RSP_R2   = 2'd3;

    st_e          st_q;
    logic [47:0]  frame_q;
    logic [5:0]   rx_cnt_q;
    logic         ncr_q;
    logic [135:0] tx_sr_q;
    logic [7:0]   tx_cnt_q;
    logic         rd_pend_q;
    logic [3:0]   card_state_q;
    logic         cmd_out_q, cmd_oe_q, rd_req_q, ill_cmd_q;
    logic [31:0]  rd_addr_q;

    logic [5:0]   idx;
    logic [31:0]  arg;
    logic         frame_ok;
    logic [39:0]  r1_hdr, r6_hdr;
    logic [3:0]   state_d;
    logic         ill_d, rd_pend_d;
    logic [1:0]   resp_d;
    logic [135:0] tx_sr_d;
    logic [7:0]   tx_cnt_d;

    // Serial CRC7 (x^7+x^3+1, seed 0) over the low n bits of d, MSB first.
    function automatic logic [6:0] crc7(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = 119; i >= 0; i--) begin
            if (i < n) begin
                fb = d[i] ^ c[6];
                c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
            end
        end
        return c;
    endfunction

    always_comb begin
        idx      = frame_q[45:40];
        arg      = frame_q[39:8];
        frame_ok = !frame_q[47] && frame_q[46] && frame_q[0];
`ifdef SD_RESP_CRC_CHECK_EN
        frame_ok = frame_ok && (frame_q[7:1] == crc7({80'b0, frame_q[47:8]}, 40));
`endif
        r1_hdr    = {2'b00, idx, 19'b0, card_state_q, 9'b0};
        r6_hdr    = {2'b00, 6'd3, RCA, 3'b0, card_state_q, 9'b0};
        state_d   = card_state_q;
        ill_d     = 1'b0;
        rd_pend_d = 1'b0;
        resp_d    = RSP_NONE;
        if (frame_ok) begin
            case (idx)
                6'd0: state_d = S_IDLE;
                6'd2: if (card_state_q == S_IDLE) begin
                          state_d = S_IDENT; resp_d = RSP_R2;
                      end else ill_d = 1'b1;
                6'd3: if (card_state_q == S_IDENT) begin
                          state_d = S_STBY; resp_d = RSP_R6;
                      end else ill_d = 1'b1;
                6'd7: if (arg[31:16] == RCA) begin
                          if (card_state_q == S_STBY) begin
                              state_d = S_TRAN; resp_d = RSP_R1;
                          end else ill_d = 1'b1;
                      end else if (card_state_q == S_TRAN) begin
                          state_d = S_STBY;
                      end else if (card_state_q != S_STBY) begin
                          ill_d = 1'b1;
                      end
                6'd17: if (card_state_q == S_TRAN) begin
                           resp_d = RSP_R1; rd_pend_d = 1'b1;
                       end else ill_d = 1'b1;
                default: ill_d = 1'b1;
            endcase
        end
        case (resp_d)
            RSP_R1:  tx_sr_d = {r1_hdr, crc7({80'b0, r1_hdr}, 40), 1'b1, 88'b0};
            RSP_R6:  tx_sr_d = {r6_hdr, crc7({80'b0, r6_hdr}, 40), 1'b1, 88'b0};
            RSP_R2:  tx_sr_d = {2'b00, 6'h3f, CID, crc7(CID, 120), 1'b1};
            default: tx_sr_d = '0;
        endcase
        tx_cnt_d = (resp_d == RSP_R2) ? 8'd135 : 8'd47;
    end

`ifndef SD_RESP_CRC_CHECK_EN
    logic unused_crc_bits;
    assign unused_crc_bits = ^frame_q[7:1];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q         <= RX_WAIT;
            frame_q      <= '0;
            rx_cnt_q     <= '0;
            ncr_q        <= 1'b0;
            tx_sr_q      <= '0;
            tx_cnt_q     <= '0;
            rd_pend_q    <= 1'b0;
            card_state_q <= S_IDLE;
            cmd_out_q    <= 1'b1;
            cmd_oe_q     <= 1'b0;
            rd_req_q     <= 1'b0;
            ill_cmd_q    <= 1'b0;
            rd_addr_q    <= '0;
        end else begin
            rd_req_q  <= 1'b0;
            ill_cmd_q <= 1'b0;
            case (st_q)
                RX_WAIT: if (!cmd_in) begin
                    frame_q  <= {frame_q[46:0], cmd_in};
                    rx_cnt_q <= '0;
                    st_q     <= RX_SHIFT;
                end
                RX_SHIFT: begin
                    frame_q  <= {frame_q[46:0], cmd_in};
                    rx_cnt_q <= rx_cnt_q + 6'd1;
                    if (rx_cnt_q == 6'd46) st_q <= DECODE;
                end
                DECODE: begin
                    card_state_q <= state_d;
                    ill_cmd_q    <= ill_d;
                    rd_pend_q    <= rd_pend_d;
                    tx_sr_q      <= tx_sr_d;
                    tx_cnt_q     <= tx_cnt_d;
                    ncr_q        <= 1'b0;
                    st_q         <= (resp_d != RSP_NONE) ? NCR : RX_WAIT;
                end
                NCR: begin
                    if (ncr_q) begin
                        cmd_oe_q  <= 1'b1;
                        cmd_out_q <= tx_sr_q[135];
                        tx_sr_q   <= {tx_sr_q[134:0], 1'b0};
                        st_q      <= TX_SHIFT;
                    end
                    ncr_q <= 1'b1;
                end
                TX_SHIFT: begin
                    if (tx_cnt_q == 8'd0) begin
                        cmd_oe_q  <= 1'b0;
                        cmd_out_q <= 1'b1;
                        rd_pend_q <= 1'b0;
                        st_q      <= RX_WAIT;
                    end else begin
                        cmd_out_q <= tx_sr_q[135];
                        tx_sr_q   <= {tx_sr_q[134:0], 1'b0};
                        tx_cnt_q  <= tx_cnt_q - 8'd1;
                        // Read request coincides with the R1 end bit on the line.
                        if (tx_cnt_q == 8'd1 && rd_pend_q) begin
                            rd_req_q  <= 1'b1;
                            rd_addr_q <= frame_q[39:8];
                        end
                    end
                end
                default: st_q <= RX_WAIT;
            endcase
        end
    end

    assign cmd_out    = cmd_out_q;
    assign cmd_oe     = cmd_oe_q;
    assign card_state = card_state_q;
    assign rd_req     = rd_req_q;
    assign rd_addr    = rd_addr_q;
    assign ill_cmd    = ill_cmd_q;

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Directed bench for sd_cmd_responder: sends command frames and checks responses and pulses.
module tb_sd_cmd_responder;

    localparam logic [119:0] TB_CID = 120'h112233445566778899AABBCCDDEEFF;
    localparam logic [15:0]  TB_RCA = 16'h0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_in = 1'b1;
    logic        cmd_out, cmd_oe, rd_req, ill_cmd;
    logic [3:0]  card_state;
    logic [31:0] rd_addr;

    int checks = 0;
    int failures = 0;

    logic [135:0] r_resp;
    int r_lat, r_oe_len, r_rd, r_ill, r_viol;

    sd_cmd_responder #(.RCA(TB_RCA), .CID(TB_CID)) dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .cmd_out(cmd_out), .cmd_oe(cmd_oe),
        .card_state(card_state), .rd_req(rd_req), .rd_addr(rd_addr), .ill_cmd(ill_cmd)
    );

    always #5 clk = ~clk;

    // CRC7 by long division of the message augmented with 7 zero bits.
    function automatic logic [6:0] bcrc(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       top;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            top = c[6];
            c = {c[5:0], d[i]} ^ (top ? 7'h09 : 7'h00);
        end
        for (int j = 0; j < 7; j++) begin
            top = c[6];
            c = {c[5:0], 1'b0} ^ (top ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    function automatic logic [47:0] mk(input logic [5:0] idx, input logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, bcrc({80'b0, h}, 40), 1'b1};
    endfunction

    function automatic logic [47:0] r1(input logic [5:0] idx, input logic [31:0] st);
        logic [39:0] h;
        h = {2'b00, idx, st};
        return {h, bcrc({80'b0, h}, 40), 1'b1};
    endfunction

    task automatic run_cmd(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            cmd_in = f[i];
        end
        r_resp = '0; r_lat = -1; r_oe_len = 0; r_rd = 0; r_ill = 0;
        for (int k = 0; k < 160; k++) begin
            @(posedge clk); #1;
            if (k == 0) cmd_in = 1'b1;
            if (cmd_oe) begin
                if (r_lat < 0) r_lat = k;
                r_oe_len++;
                r_resp = {r_resp[134:0], cmd_out};
            end else if (cmd_out !== 1'b1) r_viol++;
            if (rd_req) r_rd++;
            if (ill_cmd) r_ill++;
            if (rd_req && ill_cmd) r_viol++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        checks++;
        if (cmd_oe !== 1'b0 || cmd_out !== 1'b1) begin
            failures++; $display("FAIL reset_line oe=%b out=%b expected oe=0 out=1", cmd_oe, cmd_out);
        end
        checks++;
        if (card_state !== 4'd0 || rd_req !== 1'b0 || ill_cmd !== 1'b0 || rd_addr !== 32'h0) begin
            failures++; $display("FAIL reset_state state=%0d rd=%b ill=%b addr=%h expected 0", card_state, rd_req, ill_cmd, rd_addr);
        end
    endtask

    task automatic test_cmd0;
        logic [47:0] f;
        f = 48'h40_00000000_95;
        run_cmd(f);
        checks++;
        if (r_oe_len !== 0 || card_state !== 4'd0) begin
            failures++; $display("FAIL cmd0 oe_cycles=%0d state=%0d expected 0/0", r_oe_len, card_state);
        end
    endtask

    task automatic test_illegal;
        logic [47:0] f;
        run_cmd(mk(6'd17, 32'h0));
        checks++;
        if (r_ill !== 1 || r_oe_len !== 0 || card_state !== 4'd0) begin
            failures++; $display("FAIL cmd17_idle ill=%0d oe=%0d state=%0d expected 1/0/0", r_ill, r_oe_len, card_state);
        end
        run_cmd(mk(6'd55, 32'h0));
        checks++;
        if (r_ill !== 1 || r_oe_len !== 0) begin
            failures++; $display("FAIL cmd55 ill=%0d oe=%0d expected 1/0", r_ill, r_oe_len);
        end
        f = mk(6'd2, 32'h0);
        f[46] = 1'b0;
        run_cmd(f);
        checks++;
        if (r_ill !== 0 || r_oe_len !== 0 || card_state !== 4'd0) begin
            failures++; $display("FAIL bad_txbit ill=%0d oe=%0d state=%0d expected 0/0/0", r_ill, r_oe_len, card_state);
        end
        f = mk(6'd2, 32'h0);
        f[0] = 1'b0;
        run_cmd(f);
        checks++;
        if (r_ill !== 0 || r_oe_len !== 0 || card_state !== 4'd0) begin
            failures++; $display("FAIL bad_endbit ill=%0d oe=%0d state=%0d expected 0/0/0", r_ill, r_oe_len, card_state);
        end
    endtask

    task automatic test_cmd2;
        logic [135:0] exp;
        exp = {2'b00, 6'h3f, TB_CID, bcrc(TB_CID, 120), 1'b1};
        run_cmd(mk(6'd2, 32'h0));
        checks++;
        if (r_lat !== 3 || r_oe_len !== 136) begin
            failures++; $display("FAIL r2_timing lat=%0d len=%0d expected 3/136", r_lat, r_oe_len);
        end
        checks++;
        if (r_resp !== exp) begin
            failures++; $display("FAIL r2_data got=%h expected=%h", r_resp, exp);
        end
        checks++;
        if (card_state !== 4'd2) begin
            failures++; $display("FAIL r2_state got=%0d expected 2", card_state);
        end
    endtask

    task automatic test_cmd3;
        logic [47:0] exp;
        exp = r1(6'd3, 32'h0013_0400);
        run_cmd(mk(6'd3, 32'h0));
        checks++;
        if (r_lat !== 3 || r_oe_len !== 48 || r_resp[47:0] !== exp) begin
            failures++; $display("FAIL r6 lat=%0d len=%0d got=%h expected lat3 len48 %h", r_lat, r_oe_len, r_resp[47:0], exp);
        end
        checks++;
        if (card_state !== 4'd3) begin
            failures++; $display("FAIL r6_state got=%0d expected 3", card_state);
        end
    endtask

    task automatic test_cmd7;
        logic [47:0] exp;
        exp = r1(6'd7, 32'h0000_0600);
        run_cmd(mk(6'd7, 32'h0013_0000));
        checks++;
        if (r_lat !== 3 || r_oe_len !== 48 || r_resp[47:0] !== exp) begin
            failures++; $display("FAIL cmd7_r1 lat=%0d len=%0d got=%h expected lat3 len48 %h", r_lat, r_oe_len, r_resp[47:0], exp);
        end
        checks++;
        if (card_state !== 4'd4) begin
            failures++; $display("FAIL cmd7_state got=%0d expected 4", card_state);
        end
    endtask

    task automatic test_cmd17;
        logic [47:0] exp;
        exp = r1(6'd17, 32'h0000_0800);
        run_cmd(mk(6'd17, 32'h0000_003D));
        checks++;
        if (r_lat !== 3 || r_oe_len !== 48 || r_resp[47:0] !== exp) begin
            failures++; $display("FAIL cmd17_r1 lat=%0d len=%0d got=%h expected lat3 len48 %h", r_lat, r_oe_len, r_resp[47:0], exp);
        end
        checks++;
        if (r_rd !== 1 || r_ill !== 0 || rd_addr !== 32'h3D) begin
            failures++; $display("FAIL cmd17_rd pulses=%0d ill=%0d addr=%h expected 1/0/3d", r_rd, r_ill, rd_addr);
        end
        checks++;
        if (card_state !== 4'd4) begin
            failures++; $display("FAIL cmd17_state got=%0d expected 4", card_state);
        end
    endtask

    task automatic test_deselect;
        run_cmd(mk(6'd7, 32'h0042_0000));
        checks++;
        if (r_oe_len !== 0 || r_ill !== 0 || card_state !== 4'd3) begin
            failures++; $display("FAIL deselect oe=%0d ill=%0d state=%0d expected 0/0/3", r_oe_len, r_ill, card_state);
        end
        run_cmd(mk(6'd7, 32'h0042_0000));
        checks++;
        if (r_oe_len !== 0 || r_ill !== 0 || card_state !== 4'd3) begin
            failures++; $display("FAIL deselect_stby oe=%0d ill=%0d state=%0d expected 0/0/3", r_oe_len, r_ill, card_state);
        end
    endtask

    task automatic test_crc;
        logic [47:0] f;
        f = mk(6'd7, 32'h0013_0000) ^ 48'h2;
        run_cmd(f);
`ifdef SD_RESP_CRC_CHECK_EN
        checks++;
        if (r_oe_len !== 0 || r_ill !== 0 || card_state !== 4'd3) begin
            failures++; $display("FAIL crc_discard oe=%0d ill=%0d state=%0d expected 0/0/3", r_oe_len, r_ill, card_state);
        end
`else
        checks++;
        if (r_lat !== 3 || r_resp[47:0] !== r1(6'd7, 32'h0000_0600) || card_state !== 4'd4) begin
            failures++; $display("FAIL crc_ignored lat=%0d got=%h state=%0d expected lat3 %h state4", r_lat, r_resp[47:0], card_state, r1(6'd7, 32'h0000_0600));
        end
`endif
    endtask

    task automatic test_reset_mid_r2;
        logic [47:0] f;
        int waited;
        run_cmd(48'h40_00000000_95);
        f = mk(6'd2, 32'h0);
        for (int i = 47; i >= 0; i--) begin
            @(negedge clk);
            cmd_in = f[i];
        end
        @(negedge clk); cmd_in = 1'b1;
        waited = 0;
        while (!cmd_oe && waited < 20) begin
            @(negedge clk); waited++;
        end
        checks++;
        if (!cmd_oe) begin
            failures++; $display("FAIL mid_r2_start oe=%b expected 1", cmd_oe);
        end
        repeat (68) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (cmd_oe !== 1'b0 || cmd_out !== 1'b1 || card_state !== 4'd0) begin
            failures++; $display("FAIL async_reset oe=%b out=%b state=%0d expected 0/1/0", cmd_oe, cmd_out, card_state);
        end
        @(negedge clk); rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_oe !== 1'b0 || card_state !== 4'd0) begin
            failures++; $display("FAIL after_reset oe=%b state=%0d expected 0/0", cmd_oe, card_state);
        end
    endtask

    initial begin
        r_viol = 0;
        test_reset;
        test_cmd0;
        test_illegal;
        test_cmd2;
        test_cmd3;
        test_cmd7;
        test_cmd17;
        test_deselect;
        test_crc;
        test_reset_mid_r2;
        checks++;
        if (r_viol !== 0) begin
            failures++; $display("FAIL line_rules violations=%0d expected 0", r_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sd_cmd_responder.md
SD_CMD_RESPONDER -- requirements
Module: sd_cmd_responder

Interface
REQ-001 SHALL have parameter RCA, default 16'h0013, meaning the relative card address returned by CMD3 and matched by CMD7.
REQ-002 SHALL have parameter CID, default 120'h0, meaning CID[127:8]; CRC7 and end bit are appended internally.
REQ-003 SHALL have port clk  input  1  SD clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port cmd_in  input  1  host-to-card CMD line, idle high.
REQ-006 SHALL have port cmd_out  output  1  card-to-host CMD line data.
REQ-007 SHALL have port cmd_oe  output  1  high while a response is being driven.
REQ-008 SHALL have port card_state  output  4  current state code (IDLE 0, IDENT 2, STBY 3, TRAN 4).
REQ-009 SHALL have port rd_req  output  1  one-cycle pulse on an accepted CMD17.
REQ-010 SHALL have port rd_addr  output  32  CMD17 argument, valid from the rd_req cycle until the next CMD17.
REQ-011 SHALL have port ill_cmd  output  1  one-cycle pulse on an unsupported or out-of-state command.

Function
REQ-012 SHALL use FSM RX_WAIT -> RX_SHIFT -> DECODE -> NCR -> TX_SHIFT -> RX_WAIT; NCR is skipped straight to RX_WAIT when no response is due.
REQ-013 RX_WAIT: a cmd_in=0 sample (start bit) SHALL enter RX_SHIFT; RX_SHIFT SHALL collect 47 further bits, MSB first, into a 48-bit frame.
REQ-014 A frame with transmission bit not 1 or end bit not 1 SHALL be discarded silently, with no response and no pulse.
REQ-015 DECODE SHALL occupy the cycle after the end bit; NCR SHALL last 2 cycles, so the response start bit appears on cmd_out 3 cycles after the end-bit sample.
REQ-016 The command set SHALL be:
 - CMD0: any state -> IDLE, no response.
 - CMD2: IDLE only -> IDENT, R2.
 - CMD3: IDENT only -> STBY, R6.
 - CMD7, arg[31:16]==RCA: STBY -> TRAN, R1.
 - CMD7, any other RCA: TRAN -> STBY with no response; in STBY, ignored.
 - CMD17: TRAN only, R1; rd_req pulses on the cycle the R1 end bit is driven.
REQ-017 Any other index, or a listed command in a disallowed state, SHALL pulse ill_cmd in DECODE, give no response and leave the state unchanged.
REQ-018 R1 SHALL be 48 bits: 0, 0, index[5:0], status[31:0], CRC7, 1; status = 0 except [12:9] = card_state code before the transition.
REQ-019 R6 SHALL be 48 bits: 0, 0, index 3, {RCA, 16-bit status with [12:9] = state code}, CRC7, 1.
REQ-020 R2 SHALL be 136 bits: 0, 0, 6'b111111, CID, CRC7(CID), 1.
REQ-021 CRC7 SHALL use polynomial x^7+x^3+1 with seed 0; for R1/R6 it covers bits 47..8, for R2 it covers CID only.
REQ-022 cmd_out SHALL equal 1 whenever cmd_oe=0; cmd_oe SHALL be high from the start bit through the end bit inclusive.
REQ-023 cmd_in SHALL be ignored while in NCR or TX_SHIFT.
REQ-024 rd_req and ill_cmd SHALL never be high in the same cycle.

Reset
REQ-025 On rst assertion the block SHALL immediately (asynchronously) force FSM=RX_WAIT, card_state=IDLE, cmd_out=1, cmd_oe=0, rd_req=0, ill_cmd=0, rd_addr=0, including in the middle of a transmission.

Configuration
REQ-026 Macro SD_RESP_CRC_CHECK_EN, when defined, SHALL compare the received CRC7 against bits 47..8; on mismatch the frame is discarded, with no response, no state change and no ill_cmd pulse.
REQ-027 Without SD_RESP_CRC_CHECK_EN, received CRC7 SHALL be ignored and the frame decoded normally.

Verification
REQ-028 Stimulus: after reset, CMD0 frame 48'h40_00000000_95. Required: cmd_oe stays 0 and card_state=0.
REQ-029 Stimulus: CMD2 in IDLE. Required: a 136-bit R2 starting 3 cycles after the end bit, with correct CRC7, and card_state=2.
REQ-030 Stimulus: CMD3 then CMD7 with arg 32'h0013_0000. Required: R6 arg 32'h0013_0400 and card_state=3; then R1 status 32'h0000_0600 and card_state=4.
REQ-031 Stimulus: in TRAN, CMD17 with arg 32'h0000_003D. Required: R1 index 17, status 32'h0000_0800, one rd_req pulse, rd_addr=32'h3D.
REQ-032 Stimulus: CMD17 in IDLE. Required: ill_cmd pulse and no response. Stimulus: rst asserted halfway through an R2. Required: cmd_oe=0 and cmd_out=1 at once.
REQ-033 Stimulus, with SD_RESP_CRC_CHECK_EN defined: CMD7 with a corrupted CRC. Required: no response and state unchanged. Stimulus, without the macro: same frame. Required: normal R1.
